// File: rtl/fetch_redirect_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues icache requests, counts in-flight requests,
// arbitrates trap/mret/branch redirects and WFI sleep, and drains stale responses.
module fetch_redirect_ctrl #(
  parameter logic [31:0] RESET_PC        = 32'h8000_0000,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned CNT_W           = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        trap_i,
  input  logic [31:0] trap_vector_i,
  input  logic        mret_i,
  input  logic [31:0] mret_vector_i,
  input  logic        valid_real_branch_i,
  input  logic [31:0] real_branch_i,
  input  logic        wfi_i,
  input  logic        wake_i,
  input  logic [31:0] next_pc_i,
  input  logic        buf_full_i,
  input  logic        req_ready_i,
  output logic        req_valid_o,
  output logic [31:0] fetch_addr_o,
  input  logic        resp_valid_i,
  output logic        resp_ready_o,
  output logic        resp_accept_o,
  output logic        flush_o,
  output logic [1:0]  state_o,
  output logic        spurious_o
);

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StDrain = 2'd1,
    StSleep = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] MaxOut = CNT_W'(MAX_OUTSTANDING);

  state_e           r_state, w_state_d;
  logic [31:0]      r_pc, w_pc_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic             r_flush;
  logic             r_spurious, w_spurious_d;

  logic             w_redirect;
  logic [31:0]      w_target;
  logic             w_req_hs;
  logic             w_resp_hs;

  assign w_redirect = trap_i | mret_i | valid_real_branch_i;
  assign w_target   = trap_i ? trap_vector_i :
                      mret_i ? mret_vector_i : real_branch_i;

  assign req_valid_o   = (r_state == StRun) & ~buf_full_i & (r_cnt < MaxOut) & ~w_redirect;
  assign resp_ready_o  = (r_state == StRun) ? ~buf_full_i : 1'b1;
  assign w_req_hs      = req_valid_o & req_ready_i;
  assign w_resp_hs     = resp_valid_i & resp_ready_o;
  // Responses landing in DRAIN belong to the abandoned path and are dropped.
  assign resp_accept_o = w_resp_hs & (r_state != StDrain) & ~w_redirect;

  assign fetch_addr_o = r_pc;
  assign flush_o      = r_flush;
  assign state_o      = r_state;
  assign spurious_o   = r_spurious;

  always_comb begin
    w_cnt_d      = r_cnt;
    w_spurious_d = r_spurious;
    if (w_resp_hs && (r_cnt == '0)) begin
      w_spurious_d = 1'b1;
    end
    if (w_req_hs && !w_resp_hs) begin
      w_cnt_d = r_cnt + 1'b1;
    end else if (w_resp_hs && !w_req_hs && (r_cnt != '0)) begin
      w_cnt_d = r_cnt - 1'b1;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_pc_d    = r_pc;
    if (w_redirect) begin
      w_pc_d = w_target;
    end else if (w_req_hs) begin
      w_pc_d = next_pc_i;
    end
    unique case (r_state)
      StRun: begin
        if (w_redirect)  w_state_d = StDrain;
        else if (wfi_i)  w_state_d = StSleep;
      end
      StDrain: begin
        if (!w_redirect && (w_cnt_d == '0)) w_state_d = StRun;
      end
      StSleep: begin
        if (w_redirect)  w_state_d = StDrain;
        else if (wake_i) w_state_d = StRun;
      end
      default: w_state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= StRun;
      r_pc       <= RESET_PC;
      r_cnt      <= '0;
      r_flush    <= 1'b0;
      r_spurious <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_pc       <= w_pc_d;
      r_cnt      <= w_cnt_d;
      r_flush    <= w_redirect;
      r_spurious <= w_spurious_d;
    end
  end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Randomized bench for fetch_redirect_ctrl against a queue-based reference model of the
// fetch controller, with a few directed scenarios around redirects, WFI and backpressure.
module tb_fetch_redirect_ctrl;

  localparam int MAX = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        trap_i = 0, mret_i = 0, valid_real_branch_i = 0, wfi_i = 0, wake_i = 0;
  logic [31:0] trap_vector_i = 0, mret_vector_i = 0, real_branch_i = 0, next_pc_i = 0;
  logic        buf_full_i = 0, req_ready_i = 0, resp_valid_i = 0;
  logic        req_valid_o, resp_ready_o, resp_accept_o, flush_o, spurious_o;
  logic [31:0] fetch_addr_o;
  logic [1:0]  state_o;

  fetch_redirect_ctrl #(
    .RESET_PC       (32'h8000_0000),
    .MAX_OUTSTANDING(MAX),
    .CNT_W          (2)
  ) dut (
    .clk                (clk),
    .rstn               (rstn),
    .trap_i             (trap_i),
    .trap_vector_i      (trap_vector_i),
    .mret_i             (mret_i),
    .mret_vector_i      (mret_vector_i),
    .valid_real_branch_i(valid_real_branch_i),
    .real_branch_i      (real_branch_i),
    .wfi_i              (wfi_i),
    .wake_i             (wake_i),
    .next_pc_i          (next_pc_i),
    .buf_full_i         (buf_full_i),
    .req_ready_i        (req_ready_i),
    .req_valid_o        (req_valid_o),
    .fetch_addr_o       (fetch_addr_o),
    .resp_valid_i       (resp_valid_i),
    .resp_ready_o       (resp_ready_o),
    .resp_accept_o      (resp_accept_o),
    .flush_o            (flush_o),
    .state_o            (state_o),
    .spurious_o         (spurious_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: mode 0=RUN 1=DRAIN 2=SLEEP; in-flight requests kept as an address queue.
  int          m_mode;
  logic [31:0] m_pc;
  logic        m_flush, m_spur;
  logic [31:0] inflight[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_pc    = 32'h8000_0000;
    m_flush = 1'b0;
    m_spur  = 1'b0;
    inflight.delete();
  endtask

  task automatic idle_inputs();
    trap_i = 0; mret_i = 0; valid_real_branch_i = 0; wfi_i = 0; wake_i = 0;
    buf_full_i = 0; req_ready_i = 0; resp_valid_i = 0;
    next_pc_i = m_pc + 32'd4;
  endtask

  // Called at a falling edge with inputs already driven; checks, then advances one cycle.
  task automatic step();
    logic        redir, e_req, e_rr, e_acc, req_hs, resp_hs;
    logic [31:0] tgt;
    #1;
    redir = trap_i | mret_i | valid_real_branch_i;
    tgt   = trap_i ? trap_vector_i : (mret_i ? mret_vector_i : real_branch_i);
    e_req = (m_mode == 0) && !buf_full_i && (inflight.size() < MAX) && !redir;
    e_rr  = (m_mode != 0) || !buf_full_i;
    e_acc = resp_valid_i && e_rr && (m_mode != 1) && !redir;
    check_eq("req_valid", {31'b0, req_valid_o}, {31'b0, e_req});
    check_eq("resp_ready", {31'b0, resp_ready_o}, {31'b0, e_rr});
    check_eq("resp_accept", {31'b0, resp_accept_o}, {31'b0, e_acc});
    check_eq("fetch_addr", fetch_addr_o, m_pc);
    check_eq("state", {30'b0, state_o}, m_mode);
    check_eq("flush", {31'b0, flush_o}, {31'b0, m_flush});
    check_eq("spurious", {31'b0, spurious_o}, {31'b0, m_spur});
    req_hs  = e_req && req_ready_i;
    resp_hs = resp_valid_i && e_rr;
    @(posedge clk);
    if (resp_hs) begin
      if (inflight.size() > 0) void'(inflight.pop_front());
      else m_spur = 1'b1;
    end
    if (req_hs) inflight.push_back(m_pc);
    m_flush = redir;
    if (redir) m_pc = tgt;
    else if (req_hs) m_pc = next_pc_i;
    if (redir) m_mode = 1;
    else if (m_mode == 0 && wfi_i) m_mode = 2;
    else if (m_mode == 1 && inflight.size() == 0) m_mode = 0;
    else if (m_mode == 2 && wake_i) m_mode = 0;
    @(negedge clk);
  endtask

  initial begin
    bit reached;
    model_reset();
    idle_inputs();
    #12;
    check_eq("rst_state", {30'b0, state_o}, 0);
    check_eq("rst_pc", fetch_addr_o, 32'h8000_0000);
    check_eq("rst_flush", {31'b0, flush_o}, 0);
    check_eq("rst_spur", {31'b0, spurious_o}, 0);
    @(negedge clk);
    rstn = 1'b1;

    // Two requests issue back to back, third blocked at the outstanding limit.
    for (int i = 0; i < 3; i++) begin
      idle_inputs(); req_ready_i = 1; step();
    end
    check_eq("issued2_pc", fetch_addr_o, 32'h8000_0008);
    idle_inputs(); req_ready_i = 1; #1;
    check_eq("third_blocked", {31'b0, req_valid_o}, 0);
    @(negedge clk);

    // Simultaneous redirects with two in flight: trap wins, then drain both responses.
    idle_inputs();
    trap_i = 1; mret_i = 1; valid_real_branch_i = 1;
    trap_vector_i = 32'h0000_0100; mret_vector_i = 32'h0000_0200; real_branch_i = 32'h0000_0300;
    step();
    #1;
    check_eq("trap_pc", fetch_addr_o, 32'h0000_0100);
    check_eq("trap_flush", {31'b0, flush_o}, 1);
    check_eq("trap_drain", {30'b0, state_o}, 1);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      idle_inputs(); resp_valid_i = (inflight.size() > 0); req_ready_i = 1; step();
    end
    check_eq("post_drain_run", {30'b0, state_o}, 0);

    // WFI with one in flight: sleep, response still forwarded, wake at same pc.
    while (inflight.size() > 0) begin
      idle_inputs(); resp_valid_i = 1; step();
    end
    idle_inputs(); req_ready_i = 1; step();
    idle_inputs(); wfi_i = 1; step();
    check_eq("wfi_sleep", {30'b0, state_o}, 2);
    idle_inputs(); resp_valid_i = 1; req_ready_i = 1; step();
    for (int i = 0; i < 2; i++) begin
      idle_inputs(); req_ready_i = 1; step();
    end
    idle_inputs(); wake_i = 1; step();
    check_eq("wake_run", {30'b0, state_o}, 0);

    // Backpressure from the instruction buffer, then release.
    for (int i = 0; i < 3; i++) begin
      idle_inputs(); buf_full_i = 1; req_ready_i = 1; resp_valid_i = (inflight.size() > 0);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      idle_inputs(); req_ready_i = 1; resp_valid_i = (inflight.size() > 0); step();
    end

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      trap_i              = ($urandom_range(19) == 0);
      mret_i              = ($urandom_range(19) == 0);
      valid_real_branch_i = ($urandom_range(9) == 0);
      wfi_i               = ($urandom_range(15) == 0);
      wake_i              = ($urandom_range(3) == 0);
      buf_full_i          = ($urandom_range(3) == 0);
      req_ready_i         = ($urandom_range(9) < 7);
      resp_valid_i        = (inflight.size() > 0) && ($urandom_range(1) == 1);
      trap_vector_i       = $urandom() & 32'hFFFF_FFFC;
      mret_vector_i       = $urandom() & 32'hFFFF_FFFC;
      real_branch_i       = $urandom() & 32'hFFFF_FFFC;
      next_pc_i           = ($urandom_range(7) == 0) ? ($urandom() & 32'hFFFF_FFFC)
                                                     : m_pc + 32'd4;
      step();
      if (i == 1500) begin
        rstn = 1'b0;
        #1;
        check_eq("midrst_state", {30'b0, state_o}, 0);
        check_eq("midrst_pc", fetch_addr_o, 32'h8000_0000);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
      end
    end

    // Settle to RUN with nothing in flight, then present a response nobody asked for.
    reached = 0;
    for (int i = 0; i < 50 && !reached; i++) begin
      idle_inputs(); wake_i = 1; resp_valid_i = (inflight.size() > 0);
      step();
      reached = (m_mode == 0) && (inflight.size() == 0);
    end
    check_eq("settle_reached", {31'b0, reached}, 1);
    idle_inputs(); resp_valid_i = 1; step();
    #1;
    check_eq("spurious_set", {31'b0, spurious_o}, 1);
    @(negedge clk);
    idle_inputs(); req_ready_i = 1; step();
    check_eq("spurious_cnt0_pc", fetch_addr_o, m_pc);
    for (int i = 0; i < 3; i++) begin
      idle_inputs(); step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
